matrix_scan_scroller: RTL and testbench

- Downstream consumer of the panel's Johnson-counter frequency divider.
- Converts the divided tick (synchronous to CLK) into a one-hot column scan for the 5x7 LED matrix.
- Advances a horizontal scroll offset through the message column memory.
- Produces the message-column address and frame/shift strobes used by the row-data fetch logic.

---
 rtl/panel_pkg.sv | 18 +
 rtl/tick_edge_detect.sv | 29 ++
 rtl/matrix_scan_scroller.sv | 115 +++++++++++
 tb/tb_matrix_scan_scroller.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
// panel_pkg : shared LED-panel geometry and scan-state encoding
// Revision  : 1.0
// ============================================================================
package panel_pkg;

    localparam int c_num_cols         = 5;
    localparam int c_num_rows         = 7;
    localparam int c_msg_cols_default = 40;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_edge_detect.sv
`default_nettype none
// ============================================================================
// tick_edge_detect : one-CLK step pulse on each rising edge of a divider tick
// Revision         : 1.0
// ============================================================================
module tick_edge_detect
    import panel_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    output logic o_step
);

    logic r_tick_q;

    // Resetting to 1 hides a tick that is already high when reset releases.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_q <= 1'b1;
        end else begin
            r_tick_q <= i_tick;
        end
    end

    assign o_step = i_tick & ~r_tick_q;

endmodule
`default_nettype wire

// File: rtl/matrix_scan_scroller.sv
`default_nettype none
// ============================================================================
// matrix_scan_scroller : one-hot column scan and horizontal message scroll
// Revision             : 1.0
// ============================================================================
module matrix_scan_scroller
    import panel_pkg::*;
#(
    parameter int NUM_COLS         = c_num_cols,
    parameter int MSG_COLS         = c_msg_cols_default,
    parameter int FRAMES_PER_SHIFT = 8,
    parameter int ADDR_W           = 6
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                TICK_IN,
    input  logic                ENABLE,
    input  logic                PAUSE,
    output logic [NUM_COLS-1:0] COL_SEL,
    output logic [2:0]          COL_IDX,
    output logic [ADDR_W-1:0]   MSG_COL_ADDR,
    output logic                FRAME_DONE,
    output logic                SHIFT_DONE
);

    localparam int FC_W = (FRAMES_PER_SHIFT > 1) ? $clog2(FRAMES_PER_SHIFT) : 1;

    localparam logic [2:0]        c_last_col   = 3'(NUM_COLS - 1);
    localparam logic [FC_W-1:0]   c_last_frame = FC_W'(FRAMES_PER_SHIFT - 1);
    localparam logic [ADDR_W-1:0] c_last_msg   = ADDR_W'(MSG_COLS - 1);
    localparam logic [ADDR_W:0]   c_msg_cols   = (ADDR_W + 1)'(MSG_COLS);

    logic                w_step;
    logic [ADDR_W:0]     w_sum;

    scan_state_t         r_state;
    logic [2:0]          r_col;
    logic [FC_W-1:0]     r_frame_cnt;
    logic [ADDR_W-1:0]   r_offset;
    logic [NUM_COLS-1:0] r_col_sel;
    logic                r_frame_done;
    logic                r_shift_done;

    tick_edge_detect u_tick_edge (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .i_tick (TICK_IN),
        .o_step (w_step)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_col        <= 3'd0;
            r_frame_cnt  <= '0;
            r_offset     <= '0;
            r_col_sel    <= '0;
            r_frame_done <= 1'b0;
            r_shift_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_shift_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_col       <= 3'd0;
                    r_frame_cnt <= '0;
                    r_col_sel   <= '0;
                    if (ENABLE) begin
                        r_state   <= SCAN;
                        r_col_sel <= NUM_COLS'(1);
                    end
                end
                SCAN: begin
                    // Disable wins over a coincident step; offset is kept.
                    if (!ENABLE) begin
                        r_state     <= IDLE;
                        r_col       <= 3'd0;
                        r_frame_cnt <= '0;
                        r_col_sel   <= '0;
                    end else if (w_step) begin
                        if (r_col < c_last_col) begin
                            r_col     <= r_col + 3'd1;
                            r_col_sel <= r_col_sel << 1;
                        end else begin
                            r_col        <= 3'd0;
                            r_col_sel    <= NUM_COLS'(1);
                            r_frame_done <= 1'b1;
                            // While paused the count parks at its last value so
                            // the first unpaused wrap shifts immediately.
                            if (r_frame_cnt < c_last_frame) begin
                                r_frame_cnt <= r_frame_cnt + FC_W'(1);
                            end else if (!PAUSE) begin
                                r_frame_cnt  <= '0;
                                r_offset     <= (r_offset == c_last_msg) ? '0
                                                : r_offset + ADDR_W'(1);
                                r_shift_done <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sum = {1'b0, r_offset} + (ADDR_W + 1)'(r_col);

    assign MSG_COL_ADDR = ADDR_W'((w_sum >= c_msg_cols) ? (w_sum - c_msg_cols) : w_sum);
    assign COL_SEL      = r_col_sel;
    assign COL_IDX      = r_col;
    assign FRAME_DONE   = r_frame_done;
    assign SHIFT_DONE   = r_shift_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_scroller.sv
`default_nettype none
// ============================================================================
// tb_matrix_scan_scroller : scoreboard bench with a behavioural reference model
// Revision                : 1.0
// ============================================================================
module tb_matrix_scan_scroller;

    localparam int NC  = 5;
    localparam int MC  = 40;
    localparam int FPS = 8;
    localparam int AW  = 6;

    typedef struct packed {
        logic [NC-1:0] sel;
        logic [2:0]    idx;
        logic [AW-1:0] addr;
        logic          fd;
        logic          sd;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          TICK_IN = 1'b1;
    logic          ENABLE = 1'b0;
    logic          PAUSE = 1'b0;
    logic [NC-1:0] COL_SEL;
    logic [2:0]    COL_IDX;
    logic [AW-1:0] MSG_COL_ADDR;
    logic          FRAME_DONE;
    logic          SHIFT_DONE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t q[$];

    // Reference model state
    bit m_scan = 0;
    int m_col = 0, m_frame = 0, m_off = 0;
    bit m_prev = 1, m_fd = 0, m_sd = 0;
    int n_shift = 0;

    matrix_scan_scroller #(
        .NUM_COLS(NC), .MSG_COLS(MC), .FRAMES_PER_SHIFT(FPS), .ADDR_W(AW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .TICK_IN(TICK_IN), .ENABLE(ENABLE),
        .PAUSE(PAUSE), .COL_SEL(COL_SEL), .COL_IDX(COL_IDX),
        .MSG_COL_ADDR(MSG_COL_ADDR), .FRAME_DONE(FRAME_DONE), .SHIFT_DONE(SHIFT_DONE)
    );

    always #5 CLK = ~CLK;

    // Advance the model by one clock edge given the inputs applied before it.
    function automatic void model_edge(bit tick, bit en, bit pause, bit rst_n);
        bit step;
        m_fd = 0;
        m_sd = 0;
        if (!rst_n) begin
            m_scan = 0; m_col = 0; m_frame = 0; m_off = 0; m_prev = 1;
            return;
        end
        step   = tick && !m_prev;
        m_prev = tick;
        if (!m_scan) begin
            m_col = 0; m_frame = 0;
            if (en) m_scan = 1;
        end else if (!en) begin
            m_scan = 0; m_col = 0; m_frame = 0;
        end else if (step) begin
            m_col = m_col + 1;
            if (m_col == NC) begin
                m_col = 0;
                m_fd  = 1;
                m_frame = m_frame + 1;
                if (m_frame >= FPS) begin
                    if (!pause) begin
                        m_frame = 0;
                        m_off   = (m_off + 1) % MC;
                        m_sd    = 1;
                        n_shift++;
                    end else begin
                        m_frame = FPS - 1;
                    end
                end
            end
        end
    endfunction

    task automatic cycle(input bit tick, input bit en, input bit pause, input bit rst_n);
        exp_t e;
        @(negedge CLK);
        TICK_IN = tick; ENABLE = en; PAUSE = pause; RESET_N = rst_n;
        model_edge(tick, en, pause, rst_n);
        e.sel  = m_scan ? NC'(1 << m_col) : '0;
        e.idx  = 3'(m_col);
        e.addr = AW'((m_off + m_col) % MC);
        e.fd   = m_fd;
        e.sd   = m_sd;
        q.push_back(e);
    endtask

    task automatic tick_pulse(input int hi, input int lo, input bit en, input bit pause);
        for (int i = 0; i < hi; i++) cycle(1, en, pause, 1);
        for (int i = 0; i < lo; i++) cycle(0, en, pause, 1);
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {COL_SEL, COL_IDX, MSG_COL_ADDR, FRAME_DONE, SHIFT_DONE};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got sel=%b idx=%0d addr=%0d fd=%b sd=%b exp sel=%b idx=%0d addr=%0d fd=%b sd=%b",
                             cyc, got.sel, got.idx, got.addr, got.fd, got.sd,
                             e.sel, e.idx, e.addr, e.fd, e.sd);
                end
            end
        end
    end

    initial begin
        int guard;
        bit en, pause, tick;

        // Reset with the tick and enable already high: no spurious step.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1);
        tick_pulse(0, 2, 1, 0);
        tick_pulse(1, 1, 1, 0);

        // Long unpaused run: covers many shifts including the offset wrap 39 -> 0.
        for (int i = 0; i < MC * FPS * NC + 60; i++)
            tick_pulse($urandom_range(1, 2), $urandom_range(1, 2), 1, 0);

        // Pause across 16 frames, then release.
        for (int i = 0; i < 16 * NC; i++) tick_pulse(1, 1, 1, 1);
        for (int i = 0; i < 2 * NC; i++) tick_pulse(1, 1, 1, 0);

        // Disable on the same edge as a step while at column 2, then re-enable.
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (!(m_scan && m_col == 2) && guard < 50) begin
                tick_pulse(1, 1, 1, 0);
                guard++;
            end
            cycle(1, 0, 0, 1);
            cycle(0, 0, 0, 1);
            cycle(0, 1, 0, 1);
            tick_pulse(1, 1, 1, 0);
        end

        // Randomized mix of ticks, enable drops, pause windows and resets.
        pause = 0;
        for (int i = 0; i < 20000; i++) begin
            tick = 1'($urandom_range(0, 1));
            en   = ($urandom_range(0, 150) != 0);
            if ($urandom_range(0, 400) == 0) pause = ~pause;
            cycle(tick, en, pause, ($urandom_range(0, 4000) != 0));
        end

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left required 0", q.size());
        end
        checks++;
        if (n_shift < MC + 2) begin
            errors++;
            $display("FAIL shift_coverage got %0d required >= %0d", n_shift, MC + 2);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
